// File: rtl/packet_detect_mult_arbiter_pkg.sv
// Shared widths and result payload for the round-robin multiply arbiter.
package packet_detect_mult_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DIN_WIDTH  = 16;
  localparam int unsigned DOUT_WIDTH = 29;
  localparam int unsigned ID_WIDTH   = $clog2(NUM_REQ);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DOUT_WIDTH-1:0] data;
  } res_t;

endpackage

// File: rtl/module1_packet_detect_mult_core.sv
// Combinational signed multiplier; full product wrapped to the output width.
module module1_packet_detect_mult_core #(
  parameter int unsigned DIN_WIDTH  = packet_detect_mult_arbiter_pkg::DIN_WIDTH,
  parameter int unsigned DOUT_WIDTH = packet_detect_mult_arbiter_pkg::DOUT_WIDTH
) (
  input  logic signed [DIN_WIDTH-1:0]  a,
  input  logic signed [DIN_WIDTH-1:0]  b,
  output logic signed [DOUT_WIDTH-1:0] p
);

  localparam int unsigned FULL_WIDTH = 2 * DIN_WIDTH;

  // Sign-extend before multiplying so the product is exact, then keep the low bits.
  assign p = DOUT_WIDTH'(FULL_WIDTH'(a) * FULL_WIDTH'(b));

endmodule

// File: rtl/packet_detect_mult_arbiter.sv
// Round-robin arbiter feeding one shared signed multiplier into a single-entry
// result register with valid/ready handshakes on both sides.
module packet_detect_mult_arbiter #(
  parameter int unsigned NUM_REQ    = packet_detect_mult_arbiter_pkg::NUM_REQ,
  parameter int unsigned DIN_WIDTH  = packet_detect_mult_arbiter_pkg::DIN_WIDTH,
  parameter int unsigned DOUT_WIDTH = packet_detect_mult_arbiter_pkg::DOUT_WIDTH,
  parameter int unsigned ID_WIDTH   = packet_detect_mult_arbiter_pkg::ID_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DIN_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DIN_WIDTH-1:0] req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [DOUT_WIDTH-1:0]        res_data,
  output logic [ID_WIDTH-1:0]          res_id,
  output logic [31:0]                  grant_cnt
);

  import packet_detect_mult_arbiter_pkg::*;

  localparam int unsigned CNT_WIDTH = 32;

  res_t                  res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic [ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0]  grant_cnt_q, grant_cnt_d;

  logic                  gnt_found;
  logic [ID_WIDTH-1:0]   gnt_idx;
  logic [ID_WIDTH-1:0]   cand;
  logic                  can_accept;
  logic                  accept;
  logic signed [DIN_WIDTH-1:0]  op_a;
  logic signed [DIN_WIDTH-1:0]  op_b;
  logic signed [DOUT_WIDTH-1:0] prod;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(last_grant_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A grant is only offered when the result slot is free or draining now.
  always_comb begin
    can_accept = !res_valid_q || res_ready;
    accept     = ap_rst_n && can_accept && gnt_found;
    req_ready  = '0;
    if (accept) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    op_a = $signed(req_a[gnt_idx*DIN_WIDTH +: DIN_WIDTH]);
    op_b = $signed(req_b[gnt_idx*DIN_WIDTH +: DIN_WIDTH]);
  end

  module1_packet_detect_mult_core #(
    .DIN_WIDTH  (DIN_WIDTH),
    .DOUT_WIDTH (DOUT_WIDTH)
  ) u_mult_core (
    .a (op_a),
    .b (op_b),
    .p (prod)
  );

  always_comb begin
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    last_grant_d = last_grant_q;
    grant_cnt_d  = grant_cnt_q + CNT_WIDTH'(accept);
    if (accept) begin
      res_valid_d  = 1'b1;
      res_d.data   = prod;
      res_d.id     = gnt_idx;
      last_grant_d = gnt_idx;
    end else if (res_ready) begin
      res_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
      grant_cnt_q  <= '0;
    end else begin
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      last_grant_q <= last_grant_d;
      grant_cnt_q  <= grant_cnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_q.data;
  assign res_id    = res_q.id;
  assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_packet_detect_mult_arbiter.sv
// Bench for the round-robin multiply arbiter: directed scenarios plus a
// randomised run checked every cycle against a behavioural model.
module tb_packet_detect_mult_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int OW = 29;
  localparam int IW = 2;
  localparam longint M = 64'sd536870912;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_a;
  logic [N*DW-1:0] req_b;
  logic            res_valid;
  logic            res_ready;
  logic [OW-1:0]   res_data;
  logic [IW-1:0]   res_id;
  logic [31:0]     grant_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit          m_init = 1'b0;
  bit          m_valid;
  longint      m_data;
  int          m_id;
  int          m_last;
  logic [31:0] m_cnt;
  int          wait_acc [N];
  int          exp_g [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  packet_detect_mult_arbiter dut (
    .ap_clk    (clk),
    .ap_rst_n  (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .grant_cnt (grant_cnt)
  );

  task automatic chk(string nm, longint act, longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic longint wrap_prod(int a, int b);
    longint p;
    longint r;
    p = longint'(a) * longint'(b);
    r = p & (M - 1);
    if (r >= M / 2) r = r - M;
    return r;
  endfunction

  function automatic int op_of(logic [N*DW-1:0] v, int i);
    logic signed [DW-1:0] s;
    s = v[i*DW +: DW];
    return int'(s);
  endfunction

  // Model state advances on each rising edge from the inputs of the ending cycle.
  always @(posedge clk) begin
    int g;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 0;
      m_id    = 0;
      m_cnt   = '0;
      m_last  = N - 1;
      m_init  = 1'b1;
    end else if (m_init) begin
      g = model_grant();
      if (g >= 0 && (!m_valid || res_ready)) begin
        m_valid = 1'b1;
        m_data  = wrap_prod(op_of(req_a, g), op_of(req_b, g));
        m_id    = g;
        m_last  = g;
        m_cnt   = m_cnt + 32'd1;
      end else if (res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    bit fair_ok;
    if (m_init) begin
      g  = model_grant();
      er = '0;
      if (rst_n && !(m_valid && !res_ready) && g >= 0) er[g] = 1'b1;
      chk("req_ready", longint'(req_ready), longint'(er));
      chk("res_valid", longint'(res_valid), longint'(m_valid));
      if (m_valid) begin
        chk("res_data", longint'($signed(res_data)), m_data);
        chk("res_id", longint'(res_id), longint'(m_id));
      end
      chk("grant_cnt", longint'(grant_cnt), longint'(m_cnt));
      chk("ready_onehot", longint'($countones(req_ready) <= 1), 1);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) wait_acc[i] = 0;
      end else if ((req_ready & req_valid) != '0) begin
        fair_ok = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (!req_valid[i] || req_ready[i]) wait_acc[i] = 0;
          else wait_acc[i]++;
          if (wait_acc[i] >= N) fair_ok = 1'b0;
        end
        chk("fairness", longint'(fair_ok), 1);
      end else begin
        for (int i = 0; i < N; i++) if (!req_valid[i]) wait_acc[i] = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(int i, int a, int b);
    req_a[i*DW +: DW] = DW'(a);
    req_b[i*DW +: DW] = DW'(b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    res_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;

    // Reset values, with all requesters asserting valid.
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", longint'(req_ready), 0);
    chk("rst_res_valid", longint'(res_valid), 0);
    chk("rst_grant_cnt", longint'(grant_cnt), 0);
    chk("rst_res_data", longint'(res_data), 0);
    chk("rst_res_id", longint'(res_id), 0);

    // Single request 3 * -5.
    step();
    rst_n = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 3, -5);
    @(negedge clk);
    chk("single_ready", longint'(req_ready), 1);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_valid", longint'(res_valid), 1);
    chk("single_data", longint'($signed(res_data)), -15);
    chk("single_id", longint'(res_id), 0);
    chk("single_cnt", longint'(grant_cnt), 1);

    // All requesting from a fresh reset: grants rotate 0,1,2,3,0.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_ready", longint'(req_ready), longint'(1 << exp_g[k]));
      if (k > 0) chk("rr_res_id", longint'(res_id), longint'(exp_g[k-1]));
      step();
    end

    // Backpressure for three cycles holds the product of requester 0.
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("bp_ready", longint'(req_ready), 0);
      chk("bp_valid", longint'(res_valid), 1);
      chk("bp_id", longint'(res_id), 0);
      chk("bp_data", longint'($signed(res_data)), 10);
      step();
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", longint'(req_ready), 2);
    chk("release_data", longint'($signed(res_data)), 10);
    step();
    @(negedge clk);
    chk("release_next_id", longint'(res_id), 1);
    chk("release_next_data", longint'($signed(res_data)), 20);

    // Wrap at the product boundaries.
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req_valid = 4'b0100;
    set_op(2, -32768, -32768);
    @(negedge clk);
    chk("wrap_ready2", longint'(req_ready), 4);
    step();
    req_valid = 4'b1000;
    set_op(3, -32768, 32767);
    @(negedge clk);
    chk("wrap_data_min_min", longint'($signed(res_data)), 0);
    chk("wrap_id2", longint'(res_id), 2);
    chk("wrap_ready3", longint'(req_ready), 8);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_data_min_max", longint'($signed(res_data)), 32768);
    chk("wrap_id3", longint'(res_id), 3);
    chk("wrap_cnt", longint'(grant_cnt), 2);

    // Reset during a stall discards the pending product.
    step();
    req_valid = 4'b0001;
    set_op(0, 3, -5);
    res_ready = 1'b0;
    @(negedge clk);
    chk("stall_ready", longint'(req_ready), 1);
    step();
    rst_n = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    chk("stall_valid", longint'(res_valid), 1);
    chk("stall_rst_ready", longint'(req_ready), 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", longint'(res_valid), 0);
    chk("post_rst_cnt", longint'(grant_cnt), 0);
    chk("post_rst_ready", longint'(req_ready), 1);

    // Randomised traffic with occasional reset.
    for (int c = 0; c < 10000; c++) begin
      step();
      rst_n     = ($urandom_range(0, 499) != 0);
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(0, 3) != 0);
      req_a = {$urandom, $urandom};
      req_b = {$urandom, $urandom};
    end
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
